tron_plot_sched: RTL and testbench

TRON_PLOT_SCHED -- requirements
Module: tron_plot_sched

---
 rtl/tron_plot_sched.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_tron_plot_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tron_plot_sched.sv
// ---------------------------------------------------------------------------
// tron_plot_sched
//
// Per-tick scheduler for a two-player light-cycle game. On each tick it
// checks both player heads against the arena walls and an internal occupancy
// map, plots surviving heads to the VGA adapter write port, and records
// deaths. When a player dies, or when a clear is requested, it sweeps the
// arena back to colour 0 and empties the occupancy map.
//
// Optional feature macro: TRON_HEAD_ON_EN
//   When defined, two heads landing on the same free, in-bounds cell kill
//   both players and neither is plotted. When undefined, p1 takes the cell
//   and p2 dies by finding it occupied.
//
// Parameters
//   ARENA_X0 / ARENA_X1 : leftmost / rightmost playable column
//   ARENA_Y0 / ARENA_Y1 : top / bottom playable row
//
// Ports
//   CLOCK_50            : system clock, rising edge
//   resetn              : synchronous active-low reset; starts a full sweep
//   tick                : one-cycle pulse, both players advanced one cell
//   p1_x/p1_y/p2_x/p2_y : current head coordinates
//   clear_req           : request to wipe the arena (honoured in IDLE only)
//   x, y, colour, plot  : VGA adapter write port
//   p1_dead / p2_dead   : sticky death flags, cleared when a sweep finishes
//   busy                : high in every state except IDLE
//   round_done          : one-cycle pulse when a sweep finishes
//   overrun             : one-cycle pulse when a tick was dropped
//
// Handshake: tick and clear_req are fire-and-forget strobes with no ready.
// They are accepted only while busy is low; a tick seen while busy is high
// is discarded and reported one cycle later on overrun, a clear_req seen
// while busy is high is discarded silently.
// ---------------------------------------------------------------------------
module tron_plot_sched #(
    parameter int ARENA_X0 = 11,
    parameter int ARENA_X1 = 148,
    parameter int ARENA_Y0 = 18,
    parameter int ARENA_Y1 = 107
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       tick,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    input  logic       clear_req,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       p1_dead,
    output logic       p2_dead,
    output logic       busy,
    output logic       round_done,
    output logic       overrun
);

    localparam int MEM_W     = 160;
    localparam int MEM_DEPTH = MEM_W * 128;

    localparam logic [7:0] X0 = ARENA_X0[7:0];
    localparam logic [7:0] X1 = ARENA_X1[7:0];
    localparam logic [6:0] Y0 = ARENA_Y0[6:0];
    localparam logic [6:0] Y1 = ARENA_Y1[6:0];

    localparam logic [2:0] COL_P1 = 3'b001;
    localparam logic [2:0] COL_P2 = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_CHK1,
        S_RD2,
        S_CHK2,
        S_CLEAR
    } state_t;

    state_t      state;

    // Head coordinates captured at the accepted tick
    logic [7:0]  l1x, l2x;
    logic [6:0]  l1y, l2y;

    // Sweep position and a flag marking that the last pixel has been issued
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic        sweep_end;

    // Set when CHK1 resolved a head-on collision, so CHK2 must not plot p2
    logic        head_on;

    logic        plot_clr;

    // Occupancy map and its port signals
    logic        occ [0:MEM_DEPTH-1];
    logic        mem_q;
    logic        mem_we;
    logic        mem_wdata;
    logic [14:0] mem_waddr;
    logic [14:0] mem_raddr;

    logic        free1;
    logic        head1;
    logic        ok1;
    logic        ok2;
    logic        plot_chk;

    function automatic logic in_arena(input logic [7:0] px, input logic [6:0] py);
        return (px >= X0) && (px <= X1) && (py >= Y0) && (py <= Y1);
    endfunction

    // Row-major cell index. Columns beyond the map width are folded to 0;
    // such a head is always a wall hit, so the value read back is unused.
    function automatic logic [14:0] cell_addr(input logic [7:0] px, input logic [6:0] py);
        logic [14:0] a;
        if (px >= 8'(MEM_W)) begin
            a = '0;
        end else begin
            a = 15'(py) * 15'(MEM_W) + 15'(px);
        end
        return a;
    endfunction

    // ---------------------------------------------------------------------
    // Cell evaluation. mem_q holds the occupancy read issued in the RD
    // state just before, so in CHK1/CHK2 it describes the head under test.
    // ---------------------------------------------------------------------
    assign free1 = in_arena(l1x, l1y) && !mem_q;

`ifdef TRON_HEAD_ON_EN
    assign head1 = free1 && (l1x == l2x) && (l1y == l2y);
`else
    assign head1 = 1'b0;
`endif

    assign ok1 = free1 && !head1;
    assign ok2 = in_arena(l2x, l2y) && !mem_q && !head_on;

    // The CHK plot is decoded from registered state and the registered read
    // data, so it is high during the CHK cycle itself with x/y/colour
    // already loaded in the preceding RD cycle. Sweep plots are registered.
    assign plot_chk = ((state == S_CHK1) && ok1) || ((state == S_CHK2) && ok2);
    assign plot     = plot_clr | plot_chk;
    assign busy     = (state != S_IDLE);

    // ---------------------------------------------------------------------
    // Occupancy port control
    // ---------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        mem_waddr = cell_addr(cx, cy);
        case (state)
            S_CLEAR: begin
                mem_we = !sweep_end;
            end
            S_CHK1: begin
                mem_we    = ok1;
                mem_wdata = 1'b1;
                mem_waddr = cell_addr(l1x, l1y);
            end
            S_CHK2: begin
                mem_we    = ok2;
                mem_wdata = 1'b1;
                mem_waddr = cell_addr(l2x, l2y);
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        mem_we = mem_we && resetn;
    end

    assign mem_raddr = (state == S_RD1) ? cell_addr(l1x, l1y) : cell_addr(l2x, l2y);

    // Single-port-style map: one write and one registered read per cycle.
    // Reads only happen in RD states and writes only in CHK/CLEAR states,
    // so the two never target the same cycle's data.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            occ[mem_waddr] <= mem_wdata;
        end
        mem_q <= occ[mem_raddr];
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= S_CLEAR;
            cx         <= X0;
            cy         <= Y0;
            sweep_end  <= 1'b0;
            head_on    <= 1'b0;
            plot_clr   <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            p1_dead    <= 1'b0;
            p2_dead    <= 1'b0;
            round_done <= 1'b0;
            overrun    <= 1'b0;
            l1x        <= '0;
            l1y        <= '0;
            l2x        <= '0;
            l2y        <= '0;
        end else begin
            round_done <= 1'b0;
            overrun    <= 1'b0;
            plot_clr   <= 1'b0;

            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        l1x   <= p1_x;
                        l1y   <= p1_y;
                        l2x   <= p2_x;
                        l2y   <= p2_y;
                        state <= S_RD1;
                    end else if (clear_req) begin
                        state <= S_CLEAR;
                    end
                end

                S_RD1: begin
                    x      <= l1x;
                    y      <= l1y;
                    colour <= COL_P1;
                    state  <= S_CHK1;
                end

                S_CHK1: begin
                    if (!ok1) begin
                        p1_dead <= 1'b1;
                    end
                    if (head1) begin
                        p2_dead <= 1'b1;
                    end
                    head_on <= head1;
                    state   <= S_RD2;
                end

                S_RD2: begin
                    x      <= l2x;
                    y      <= l2y;
                    colour <= COL_P2;
                    state  <= S_CHK2;
                end

                S_CHK2: begin
                    if (!ok2) begin
                        p2_dead <= 1'b1;
                    end
                    head_on <= 1'b0;
                    if (p1_dead || !ok2) begin
                        state <= S_CLEAR;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_CLEAR: begin
                    if (!sweep_end) begin
                        plot_clr <= 1'b1;
                        x        <= cx;
                        y        <= cy;
                        colour   <= 3'b000;
                        // Column-major sweep: y is the inner loop
                        if (cy == Y1) begin
                            cy <= Y0;
                            if (cx == X1) begin
                                sweep_end <= 1'b1;
                            end else begin
                                cx <= cx + 8'd1;
                            end
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        // Cycle after the last pixel: close the round
                        round_done <= 1'b1;
                        p1_dead    <= 1'b0;
                        p2_dead    <= 1'b0;
                        cx         <= X0;
                        cy         <= Y0;
                        sweep_end  <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tron_plot_sched.sv
// ---------------------------------------------------------------------------
// tb_tron_plot_sched
//
// Self-checking bench for tron_plot_sched at default parameters. A
// behavioural model keeps its own occupancy array and decides, per round,
// which heads die and which cells get plotted; expected plots are queued in
// exp_q and compared cycle by cycle. Arena sweeps are checked for pixel
// count, order, colour and the round_done pulse.
// Build with +define+TRON_HEAD_ON_EN to check the head-on variant.
// ---------------------------------------------------------------------------
module tb_tron_plot_sched;

    localparam int X0    = 11;
    localparam int X1    = 148;
    localparam int Y0    = 18;
    localparam int Y1    = 107;
    localparam int SWEEP = (X1 - X0 + 1) * (Y1 - Y0 + 1);

    // ---------------- clock / reset ----------------
    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       tick     = 1'b0;
    logic       clear_req = 1'b0;
    logic [7:0] p1_x = '0;
    logic [6:0] p1_y = '0;
    logic [7:0] p2_x = '0;
    logic [6:0] p2_y = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       p1_dead;
    logic       p2_dead;
    logic       busy;
    logic       round_done;
    logic       overrun;

    always #10 CLOCK_50 = ~CLOCK_50;

    tron_plot_sched dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .tick       (tick),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .clear_req  (clear_req),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .p1_dead    (p1_dead),
        .p2_dead    (p2_dead),
        .busy       (busy),
        .round_done (round_done),
        .overrun    (overrun)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    bit          occ_m [160][128];
    logic [17:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit wall(input int px, input int py);
        return (px < X0) || (px > X1) || (py < Y0) || (py > Y1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 160; i++) begin
            for (int j = 0; j < 128; j++) begin
                occ_m[i][j] = 1'b0;
            end
        end
    endtask

    task automatic pick_free(output int px, output int py, input int ax, input int ay);
        do begin
            px = $urandom_range(X1, X0);
            py = $urandom_range(Y1, Y0);
        end while (occ_m[px][py] || ((px == ax) && (py == ay)));
    endtask

    // Watch a sweep to completion: pixel count, order, colour 0, then the
    // round_done pulse with dead flags cleared and busy low.
    task automatic wait_sweep(input string name);
        int n    = 0;
        int errs = 0;
        int ex   = X0;
        int ey   = Y0;
        bit seen = 1'b0;
        for (int c = 0; (c < 20000) && !seen; c++) begin
            @(negedge CLOCK_50);
            if (round_done) begin
                seen = 1'b1;
            end else if (plot) begin
                if ({x, y, colour} !== {8'(ex), 7'(ey), 3'b000}) errs++;
                n++;
                ey++;
                if (ey > Y1) begin
                    ey = Y0;
                    ex++;
                end
            end
        end
        check({name, "_sweep_done"}, 32'(seen), 32'd1);
        check({name, "_sweep_count"}, 32'(n), 32'(SWEEP));
        check({name, "_sweep_order_errs"}, 32'(errs), 32'd0);
        check({name, "_idle_after_sweep"}, 32'(busy), 32'd0);
        check({name, "_p1_dead_cleared"}, 32'(p1_dead), 32'd0);
        check({name, "_p2_dead_cleared"}, 32'(p2_dead), 32'd0);
        @(negedge CLOCK_50);
        check({name, "_round_done_one_cycle"}, 32'(round_done), 32'd0);
        model_clear();
    endtask

    // One tick with model prediction. Optional extra tick two cycles later,
    // clear_req together with the tick, or clear_req mid-round.
    task automatic run_round(input int ax, input int ay, input int bx, input int by,
                             input bit extra_tick, input bit clr_at_tick,
                             input bit clr_mid, input string name);
        bit          d1, d2, pl1, pl2, head;
        logic [17:0] e;
        // model
        head = 1'b0;
        d1   = wall(ax, ay) ? 1'b1 : occ_m[ax][ay];
`ifdef TRON_HEAD_ON_EN
        if (!d1 && (ax == bx) && (ay == by)) head = 1'b1;
`endif
        if (head) begin
            d1 = 1'b1; d2 = 1'b1; pl1 = 1'b0; pl2 = 1'b0;
        end else begin
            pl1 = !d1;
            if (pl1) begin
                occ_m[ax][ay] = 1'b1;
                exp_q.push_back({8'(ax), 7'(ay), 3'b001});
            end
            d2  = wall(bx, by) ? 1'b1 : occ_m[bx][by];
            pl2 = !d2;
            if (pl2) begin
                occ_m[bx][by] = 1'b1;
                exp_q.push_back({8'(bx), 7'(by), 3'b100});
            end
        end

        // stimulus and per-cycle checks
        @(negedge CLOCK_50);
        p1_x = 8'(ax); p1_y = 7'(ay); p2_x = 8'(bx); p2_y = 7'(by);
        tick = 1'b1;
        clear_req = clr_at_tick;
        for (int k = 0; k <= 6; k++) begin
            @(negedge CLOCK_50);
            case (k)
                0: begin
                    check({name, "_rd1_plot"}, 32'(plot), 32'd0);
                    check({name, "_rd1_busy"}, 32'(busy), 32'd1);
                    tick = 1'b0;
                    clear_req = 1'b0;
                end
                1: begin
                    check({name, "_p1_plot"}, 32'(plot), 32'(pl1));
                    if (pl1) begin
                        e = exp_q.pop_front();
                        check({name, "_p1_xyc"}, 32'({x, y, colour}), 32'(e));
                    end
                    if (extra_tick) tick = 1'b1;
                    if (clr_mid) clear_req = 1'b1;
                end
                2: begin
                    check({name, "_rd2_plot"}, 32'(plot), 32'd0);
                    check({name, "_p1_dead"}, 32'(p1_dead), 32'(d1));
                    check({name, "_overrun"}, 32'(overrun), 32'(extra_tick));
                    tick = 1'b0;
                    clear_req = 1'b0;
                end
                3: begin
                    check({name, "_p2_plot"}, 32'(plot), 32'(pl2));
                    if (pl2) begin
                        e = exp_q.pop_front();
                        check({name, "_p2_xyc"}, 32'({x, y, colour}), 32'(e));
                    end
                    check({name, "_overrun_once"}, 32'(overrun), 32'd0);
                end
                4: begin
                    check({name, "_end_plot"}, 32'(plot), 32'd0);
                    check({name, "_end_p1_dead"}, 32'(p1_dead), 32'(d1));
                    check({name, "_end_p2_dead"}, 32'(p2_dead), 32'(d2));
                    check({name, "_end_busy"}, 32'(busy), 32'(d1 | d2));
                    if (d1 | d2) break;
                end
                default: begin
                    check({name, "_quiet_plot"}, 32'(plot), 32'd0);
                    check({name, "_quiet_busy"}, 32'(busy), 32'd0);
                end
            endcase
        end
        if (d1 | d2) wait_sweep(name);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ax, ay, bx, by;
        model_clear();

        // reset values
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_xyc", 32'({x, y, colour}), 32'd0);
        check("rst_p1_dead", 32'(p1_dead), 32'd0);
        check("rst_p2_dead", 32'(p2_dead), 32'd0);
        check("rst_round_done", 32'(round_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        resetn = 1'b1;
        wait_sweep("init");

        // basic round
        run_round(25, 100, 135, 100, 1'b0, 1'b0, 1'b0, "basic");

        // randomized free-cell rounds
        for (int r = 0; r < 10; r++) begin
            pick_free(ax, ay, -1, -1);
            pick_free(bx, by, ax, ay);
            run_round(ax, ay, bx, by, 1'b0, 1'b0, (r == 3), $sformatf("rand%0d", r));
        end

        // overrun: second tick two cycles after the first
        pick_free(ax, ay, -1, -1);
        pick_free(bx, by, ax, ay);
        run_round(ax, ay, bx, by, 1'b1, 1'b0, 1'b0, "overrun");

        // tick and clear_req together: tick wins
        pick_free(ax, ay, -1, -1);
        pick_free(bx, by, ax, ay);
        run_round(ax, ay, bx, by, 1'b0, 1'b1, 1'b0, "tick_prio");

        // p1 onto its own trail
        pick_free(bx, by, 25, 100);
        run_round(25, 100, bx, by, 1'b0, 1'b0, 1'b0, "p1_trail");

        // p2 into the right wall
        pick_free(ax, ay, 149, 60);
        run_round(ax, ay, 149, 60, 1'b0, 1'b0, 1'b0, "p2_wall");

        // equal heads
        run_round(80, 60, 80, 60, 1'b0, 1'b0, 1'b0, "same_cell");

        // clear_req from IDLE, then reset in the middle of the sweep
        @(negedge CLOCK_50);
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        repeat (300) @(negedge CLOCK_50);
        check("clr_plotting", 32'(plot), 32'd1);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("midrst_plot", 32'(plot), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        resetn = 1'b1;
        wait_sweep("midrst");

        // arena usable again after the restarted sweep
        run_round(25, 100, 135, 100, 1'b0, 1'b0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
